cache_mem_responder: RTL and testbench

//  Memory-side responder for the caches_if protocol: services icache word reads and dcache

---
 rtl/cache_mem_responder.sv | 153 +++++++++++++++
 tb/tb_cache_mem_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the caches_if protocol: arbitrates icache/dcache word
// requests onto a single RAM port, dcache first, with a starvation bound for icache.
module cache_mem_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        DREAD,
        DWRITE,
        IREAD,
        RETRY
    } state_t;

    state_t           state;
    state_t           state_next;
    state_t           retry_state;
    state_t           retry_next;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_next;
    logic             d_done;
    logic             i_done;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            retry_state <= IDLE;
            starve_cnt  <= '0;
        end else begin
            state       <= state_next;
            retry_state <= retry_next;
            starve_cnt  <= starve_next;
        end
    end

    // Outputs are decoded from the registered grant, so a reset forces them idle at once.
    always_comb begin
        state_next = state;
        retry_next = retry_state;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        d_done     = 1'b0;
        i_done     = 1'b0;
        case (state)
            IDLE: begin
                if (iREN && starve_cnt == STARVE_LIM) state_next = IREAD;
                else if (dWEN)                        state_next = DWRITE;
                else if (dREN)                        state_next = DREAD;
                else if (iREN)                        state_next = IREAD;
            end
            DREAD: begin
                if (!dREN) begin
                    state_next = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = daddr;
                    if (ramstate == RAM_ACCESS) begin
                        dwait      = 1'b0;
                        dload      = ramload;
                        d_done     = 1'b1;
                        state_next = IDLE;
                    end else if (ramstate == RAM_ERROR) begin
                        retry_next = DREAD;
                        state_next = RETRY;
                    end
                end
            end
            DWRITE: begin
                if (!dWEN) begin
                    state_next = IDLE;
                end else begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ramstate == RAM_ACCESS) begin
                        dwait      = 1'b0;
                        d_done     = 1'b1;
                        state_next = IDLE;
                    end else if (ramstate == RAM_ERROR) begin
                        retry_next = DWRITE;
                        state_next = RETRY;
                    end
                end
            end
            IREAD: begin
                if (!iREN) begin
                    state_next = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == RAM_ACCESS) begin
                        iwait      = 1'b0;
                        iload      = ramload;
                        i_done     = 1'b1;
                        state_next = IDLE;
                    end else if (ramstate == RAM_ERROR) begin
                        retry_next = IREAD;
                        state_next = RETRY;
                    end
                end
            end
            RETRY: begin
                state_next = retry_state;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counts dcache wins while icache waits; any icache idle cycle or win resets it.
    always_comb begin
        starve_next = starve_cnt;
        if (!iREN || i_done) begin
            starve_next = '0;
        end else if (d_done && starve_cnt != STARVE_LIM) begin
            starve_next = starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: directed protocol scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_cache_mem_responder;

    localparam int STARVE_MAX = 4;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who holds the RAM port and whether we are arbitrating,
    // serving, or sitting out a retry gap after a RAM error.
    int m_phase  = 0;
    int m_owner  = 0;
    int m_starve = 0;

    cache_mem_responder #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .iREN(iREN),
        .iaddr(iaddr),
        .iwait(iwait),
        .iload(iload),
        .dREN(dREN),
        .dWEN(dWEN),
        .daddr(daddr),
        .dstore(dstore),
        .dwait(dwait),
        .dload(dload),
        .ramREN(ramREN),
        .ramWEN(ramWEN),
        .ramaddr(ramaddr),
        .ramstore(ramstore),
        .ramload(ramload),
        .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] ds, input logic ir, input logic [31:0] ia,
                         input logic [1:0] rs, input logic [31:0] rl);
        dREN = dr; dWEN = dw; daddr = da; dstore = ds;
        iREN = ir; iaddr = ia; ramstate = rs; ramload = rl;
    endtask

    // One clock: check every output against the model, then advance the model.
    task automatic cycle();
        logic        e_iwait, e_dwait, e_ren, e_wen, live;
        logic [31:0] e_iload, e_dload, e_addr, e_store;
        bit          d_fin, i_fin;
        int          n_phase, n_owner, n_starve;
        #1;
        if (RST) begin
            m_phase = 0; m_owner = 0; m_starve = 0;
        end
        e_iwait = 1; e_dwait = 1; e_ren = 0; e_wen = 0;
        e_iload = 0; e_dload = 0; e_addr = 0; e_store = 0;
        d_fin = 0; i_fin = 0;
        n_phase = m_phase; n_owner = m_owner;
        if (m_phase == 1) begin
            live = (m_owner == 1) ? dREN : (m_owner == 2) ? dWEN : iREN;
            if (!live) begin
                n_phase = 0;
            end else begin
                e_ren  = (m_owner != 2);
                e_wen  = (m_owner == 2);
                e_addr = (m_owner == 3) ? iaddr : daddr;
                e_store = (m_owner == 2) ? dstore : 32'h0;
                if (ramstate == 2'd2) begin
                    n_phase = 0;
                    if (m_owner == 3) begin
                        e_iwait = 0; e_iload = ramload; i_fin = 1;
                    end else begin
                        e_dwait = 0; d_fin = 1;
                        if (m_owner == 1) e_dload = ramload;
                    end
                end else if (ramstate == 2'd3) begin
                    n_phase = 2;
                end
            end
        end else if (m_phase == 2) begin
            n_phase = 1;
        end else begin
            if (iREN && m_starve == STARVE_MAX) begin n_phase = 1; n_owner = 3; end
            else if (dWEN)                      begin n_phase = 1; n_owner = 2; end
            else if (dREN)                      begin n_phase = 1; n_owner = 1; end
            else if (iREN)                      begin n_phase = 1; n_owner = 3; end
        end
        if (!iREN || i_fin)                      n_starve = 0;
        else if (d_fin && m_starve < STARVE_MAX) n_starve = m_starve + 1;
        else                                     n_starve = m_starve;
        chk("iwait", 32'(iwait), 32'(e_iwait));
        chk("dwait", 32'(dwait), 32'(e_dwait));
        chk("iload", iload, e_iload);
        chk("dload", dload, e_dload);
        chk("ramREN", 32'(ramREN), 32'(e_ren));
        chk("ramWEN", 32'(ramWEN), 32'(e_wen));
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_store);
        @(posedge CLK);
        if (RST) begin
            m_phase = 0; m_owner = 0; m_starve = 0;
        end else begin
            m_phase = n_phase; m_owner = n_owner; m_starve = n_starve;
        end
        @(negedge CLK);
    endtask

    initial begin
        int d_seen;
        int i_seen;
        int first_i;
        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 2'd0, 0);
        #1;
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        cycle();

        // dcache read with two BUSY cycles before ACCESS
        drive(1, 0, 32'h100, 0, 0, 0, 2'd1, 0);
        cycle();
        cycle();
        chk("dr_busy_ren", 32'(ramREN), 32'd1);
        chk("dr_busy_addr", ramaddr, 32'h100);
        cycle();
        drive(1, 0, 32'h100, 0, 0, 0, 2'd2, 32'hDEADBEEF);
        #1;
        chk("dr_done_dwait", 32'(dwait), 32'd0);
        chk("dr_done_dload", dload, 32'hDEADBEEF);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 2'd0, 0);
        #1;
        chk("dr_after_dwait", 32'(dwait), 32'd1);
        chk("dr_after_ren", 32'(ramREN), 32'd0);
        cycle();

        // simultaneous icache and dcache reads: dcache first
        drive(1, 0, 32'h80, 0, 1, 32'h40, 2'd2, 32'h1111);
        cycle();
        #1;
        chk("pri_d_addr", ramaddr, 32'h80);
        chk("pri_d_iwait", 32'(iwait), 32'd1);
        cycle();
        drive(0, 0, 0, 0, 1, 32'h40, 2'd2, 32'h2222);
        cycle();
        #1;
        chk("pri_i_addr", ramaddr, 32'h40);
        chk("pri_i_iwait", 32'(iwait), 32'd0);
        chk("pri_i_iload", iload, 32'h2222);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 2'd0, 0);
        cycle();

        // starvation bound: both held, RAM always ready
        drive(1, 0, 32'h500, 0, 1, 32'h600, 2'd2, 32'h3333);
        d_seen = 0; i_seen = 0; first_i = -1;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (!dwait && i_seen == 0) d_seen++;
            if (!iwait) begin
                i_seen++;
                if (first_i < 0) first_i = d_seen;
            end
            cycle();
        end
        chk("starve_d_before_i", 32'(first_i), 32'(STARVE_MAX));
        chk("starve_i_once", 32'(i_seen), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 2'd0, 0);
        cycle();
        cycle();

        // dcache write
        drive(0, 1, 32'h3100, 32'h12, 0, 0, 2'd2, 32'h9);
        cycle();
        #1;
        chk("dw_wen", 32'(ramWEN), 32'd1);
        chk("dw_addr", ramaddr, 32'h3100);
        chk("dw_store", ramstore, 32'h12);
        chk("dw_dwait", 32'(dwait), 32'd0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 2'd0, 0);
        cycle();

        // RAM error once, then retry and completion
        drive(1, 0, 32'h300, 0, 0, 0, 2'd3, 0);
        cycle();
        cycle();
        drive(1, 0, 32'h300, 0, 0, 0, 2'd1, 0);
        #1;
        chk("retry_ren", 32'(ramREN), 32'd0);
        chk("retry_dwait", 32'(dwait), 32'd1);
        cycle();
        drive(1, 0, 32'h300, 0, 0, 0, 2'd2, 32'h55);
        #1;
        chk("retry_reissue_addr", ramaddr, 32'h300);
        chk("retry_dload", dload, 32'h55);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 2'd0, 0);
        cycle();

        // reset during a BUSY dcache read
        drive(1, 0, 32'h200, 0, 0, 0, 2'd1, 32'h77);
        cycle();
        cycle();
        RST = 1'b1;
        #1;
        chk("rst_mid_ren", 32'(ramREN), 32'd0);
        chk("rst_mid_dwait", 32'(dwait), 32'd1);
        cycle();
        RST = 1'b0;
        drive(1, 0, 32'h200, 0, 0, 0, 2'd2, 32'h77);
        cycle();
        cycle();
        drive(0, 0, 0, 0, 0, 0, 2'd0, 0);
        cycle();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            int r;
            if ($urandom_range(0, 7) == 0) dREN = ~dREN;
            if ($urandom_range(0, 11) == 0) dWEN = ~dWEN;
            if ($urandom_range(0, 7) == 0) iREN = ~iREN;
            if ($urandom_range(0, 3) == 0) daddr = $urandom;
            if ($urandom_range(0, 3) == 0) iaddr = $urandom;
            dstore  = $urandom;
            ramload = $urandom;
            r = $urandom_range(0, 99);
            ramstate = (r < 40) ? 2'd2 : (r < 65) ? 2'd1 : (r < 80) ? 2'd0 : 2'd3;
            RST = ($urandom_range(0, 199) == 0);
            cycle();
        end
        RST = 1'b0;

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
